// File: rtl/johnson_phase_monitor_if.sv
// Bus between a 4-bit Johnson counter and the phase monitor: the counter
// state going in, the qualified phase, lock status and error/revolution
// reporting coming out.
interface johnson_phase_monitor_if;
    logic [3:0] q;
    logic [2:0] phase;
    logic [7:0] phase_oh;
    logic       valid;
    logic [1:0] state;
    logic       illegal;
    logic       seq_err;
    logic       wrap;
    logic [7:0] rev_count;
    logic [7:0] err_count;

    // Driver side: the counter (or a bench) supplies q and observes results.
    modport master (
        output q,
        input  phase, phase_oh, valid, state, illegal, seq_err, wrap,
               rev_count, err_count
    );

    // Monitor side: consumes q and produces the qualified phase information.
    modport slave (
        input  q,
        output phase, phase_oh, valid, state, illegal, seq_err, wrap,
               rev_count, err_count
    );
endinterface

// File: rtl/johnson_phase_monitor.sv
// Johnson counter phase monitor. Registers the counter state, checks each
// code against the 8-code Johnson set and each transition for hold/successor,
// qualifies the phase through a SEARCH/TRACK/LOCKED state machine, and keeps
// a revolution counter and a saturating error counter.
module johnson_phase_monitor #(
    parameter int LOCK_STEPS = 4
) (
    input logic                    clk,
    input logic                    reset,
    johnson_phase_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N = LOCK_STEPS[3:0];

    function automatic logic is_legal(input logic [3:0] c);
        case (c)
            4'b0000, 4'b0001, 4'b0011, 4'b0111,
            4'b1111, 4'b1110, 4'b1100, 4'b1000: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] phase_of(input logic [3:0] c);
        case (c)
            4'b0001: return 3'd1;
            4'b0011: return 3'd2;
            4'b0111: return 3'd3;
            4'b1111: return 3'd4;
            4'b1110: return 3'd5;
            4'b1100: return 3'd6;
            4'b1000: return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] successor(input logic [3:0] c);
        return {c[2:0], ~c[3]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Stage p0: raw counter state captured; stage p1: the code before it.
    logic [3:0] q_p0;
    logic [3:0] prev_p1;

    state_t     state_q, state_n;
    logic [3:0] good_cnt_q, good_cnt_n;
    logic [2:0] phase_q;
    logic       illegal_q, seq_err_q, wrap_q;
    logic [7:0] rev_q, err_q;

    logic cur_legal, prev_legal;
    logic is_hold, is_good, is_skip, step_err, wrap_n;

    // A legal code after an illegal one is neither GOOD nor SKIP (restart),
    // because both of those require prev to be legal.
    assign cur_legal  = is_legal(q_p0);
    assign prev_legal = is_legal(prev_p1);
    assign is_hold    = cur_legal && (q_p0 == prev_p1);
    assign is_good    = prev_legal && (q_p0 == successor(prev_p1));
    assign is_skip    = prev_legal && cur_legal && !is_hold && !is_good;
    assign step_err   = !cur_legal || is_skip;
    assign wrap_n     = (state_q == LOCKED) && is_good && (prev_p1 == 4'b1000);

    // Lock qualification: next state and good-step count from the classification.
    always_comb begin
        state_n    = state_q;
        good_cnt_n = good_cnt_q;
        case (state_q)
            SEARCH: begin
                if (cur_legal) begin
                    state_n    = TRACK;
                    good_cnt_n = 4'd0;
                end
            end
            TRACK: begin
                if (step_err) begin
                    state_n    = SEARCH;
                    good_cnt_n = 4'd0;
                end else if (is_good) begin
                    good_cnt_n = good_cnt_q + 4'd1;
                    if (good_cnt_n == LOCK_N) begin
                        state_n = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (step_err) begin
                    state_n    = SEARCH;
                    good_cnt_n = 4'd0;
                end
            end
            default: begin
                state_n    = SEARCH;
                good_cnt_n = 4'd0;
            end
        endcase
    end

    // State machine register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SEARCH;
            good_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_n;
            good_cnt_q <= good_cnt_n;
        end
    end

    // Input pipeline, phase tracking, pulses and counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_p0      <= 4'b0000;
            prev_p1   <= 4'b0000;
            phase_q   <= 3'd0;
            illegal_q <= 1'b0;
            seq_err_q <= 1'b0;
            wrap_q    <= 1'b0;
            rev_q     <= 8'd0;
            err_q     <= 8'd0;
        end else begin
            q_p0      <= bus.q;
            prev_p1   <= q_p0;
            if (cur_legal) begin
                phase_q <= phase_of(q_p0);
            end
            illegal_q <= !cur_legal;
            seq_err_q <= is_skip;
            wrap_q    <= wrap_n;
            if (wrap_n) begin
                rev_q <= rev_q + 8'd1;
            end
            if (step_err) begin
                err_q <= sat_inc(err_q);
            end
        end
    end

    // Output stage: everything derives directly from registered state.
    logic vld_p1;
    assign vld_p1        = (state_q == LOCKED);
    assign bus.valid     = vld_p1;
    assign bus.state     = state_q;
    assign bus.phase     = phase_q;
    assign bus.phase_oh  = vld_p1 ? (8'b0000_0001 << phase_q) : 8'h00;
    assign bus.illegal   = illegal_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.wrap      = wrap_q;
    assign bus.rev_count = rev_q;
    assign bus.err_count = err_q;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Bench for johnson_phase_monitor: a reference model predicts each
// evaluation when its code is driven, the prediction is queued, and it is
// popped and compared when the monitor shows that evaluation two edges later.
module tb_johnson_phase_monitor;
    localparam int LOCK = 4;

    logic clk;
    logic reset;
    johnson_phase_monitor_if bus();

    johnson_phase_monitor #(.LOCK_STEPS(LOCK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic       v;
        logic [2:0] ph;
        logic [7:0] oh;
        logic       ill;
        logic       se;
        logic       wr;
        logic [7:0] rev;
        logic [7:0] err;
    } exp_t;

    logic [3:0] J [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                          4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [3:0] T3 [11] = '{4'b0001, 4'b0011, 4'b1010, 4'b0011, 4'b0111, 4'b1111,
                            4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
    logic [3:0] T5 [9] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001,
                           4'b0011, 4'b0111, 4'b1111, 4'b1110};

    exp_t  sb[$];
    int    n_vec;
    int    n_fail;
    string tst;

    logic [3:0] m_prev;
    int m_state, m_cnt, m_phase, m_rev, m_err;

    function automatic int idx_of(input logic [3:0] c);
        for (int i = 0; i < 8; i++) begin
            if (J[i] == c) return i;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tst, tag, obs, exp_v);
        end
    endtask

    task automatic model_eval(input logic [3:0] c);
        int ci, pi;
        bit ill, hold, good, skip, wr;
        exp_t e;
        ci   = idx_of(c);
        pi   = idx_of(m_prev);
        ill  = (ci < 0);
        hold = !ill && (c == m_prev);
        good = (pi >= 0) && (ci >= 0) && (ci == (pi + 1) % 8);
        skip = (pi >= 0) && !ill && !hold && !good;
        wr   = (m_state == 2) && good && (pi == 7);
        case (m_state)
            0: if (!ill) begin m_state = 1; m_cnt = 0; end
            1: begin
                if (ill || skip) begin
                    m_state = 0; m_cnt = 0;
                end else if (good) begin
                    m_cnt++;
                    if (m_cnt == LOCK) m_state = 2;
                end
            end
            default: if (ill || skip) begin m_state = 0; m_cnt = 0; end
        endcase
        if (!ill) m_phase = ci;
        if (wr) m_rev = (m_rev + 1) % 256;
        if ((ill || skip) && m_err < 255) m_err++;
        m_prev = c;
        e.st  = 2'(m_state);
        e.v   = (m_state == 2);
        e.ph  = 3'(m_phase);
        e.oh  = (m_state == 2) ? 8'(1 << m_phase) : 8'h00;
        e.ill = ill;
        e.se  = skip;
        e.wr  = wr;
        e.rev = 8'(m_rev);
        e.err = 8'(m_err);
        sb.push_back(e);
    endtask

    // Reset discards pending predictions; the first evaluation after release
    // is of the reset value 0000 held in the input register.
    task automatic model_reset();
        m_prev = 4'b0000; m_state = 0; m_cnt = 0;
        m_phase = 0; m_rev = 0; m_err = 0;
        sb.delete();
        model_eval(4'b0000);
    endtask

    task automatic check_outputs(input exp_t e);
        check("state",     32'(bus.state),     32'(e.st));
        check("valid",     32'(bus.valid),     32'(e.v));
        check("phase",     32'(bus.phase),     32'(e.ph));
        check("phase_oh",  32'(bus.phase_oh),  32'(e.oh));
        check("illegal",   32'(bus.illegal),   32'(e.ill));
        check("seq_err",   32'(bus.seq_err),   32'(e.se));
        check("wrap",      32'(bus.wrap),      32'(e.wr));
        check("rev_count", 32'(bus.rev_count), 32'(e.rev));
        check("err_count", 32'(bus.err_count), 32'(e.err));
    endtask

    task automatic step(input logic [3:0] qv, input logic rv);
        exp_t e;
        @(negedge clk);
        bus.q = qv;
        reset = rv;
        if (rv) model_reset();
        else    model_eval(qv);
        @(posedge clk);
        #1;
        if (rv) begin
            e.st = 2'd0; e.v = 1'b0; e.ph = 3'd0; e.oh = 8'h00;
            e.ill = 1'b0; e.se = 1'b0; e.wr = 1'b0; e.rev = 8'd0; e.err = 8'd0;
            check_outputs(e);
        end else begin
            check("sb_depth", 32'(sb.size() >= 2), 1);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                check_outputs(e);
            end
        end
    endtask

    initial begin
        int wraps;
        n_vec  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.q  = 4'b0000;
        tst    = "reset";
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        tst = "lock";
        for (int i = 0; i <= 8; i++) begin
            step(J[i % 8], 1'b0);
            if (i == 4) begin
                check("state_track", 32'(bus.state), 1);
                check("valid_early", 32'(bus.valid), 0);
            end
            if (i == 5) begin
                check("state_locked", 32'(bus.state), 2);
                check("valid_locked", 32'(bus.valid), 1);
            end
        end

        tst   = "rev";
        wraps = 0;
        for (int k = 0; k < 16; k++) begin
            step(J[(9 + k) % 8], 1'b0);
            if (k == 0) begin
                check("first_oh", 32'(bus.phase_oh), 32'h01);
                check("first_state", 32'(bus.state), 2);
                check("first_err", 32'(bus.err_count), 0);
            end
            wraps += int'(bus.wrap);
        end
        check("wrap_pulses", 32'(wraps), 2);
        check("rev_total", 32'(bus.rev_count), 2);

        tst = "illegal";
        for (int t = 0; t < 11; t++) begin
            step(T3[t], 1'b0);
            if (t == 2) begin
                check("phase2", 32'(bus.phase), 2);
                check("locked", 32'(bus.state), 2);
            end
            if (t == 3) begin
                check("pulse", 32'(bus.illegal), 1);
                check("valid", 32'(bus.valid), 0);
                check("state", 32'(bus.state), 0);
                check("phase_held", 32'(bus.phase), 2);
                check("err", 32'(bus.err_count), 1);
            end
            if (t == 4) begin
                check("restart_state", 32'(bus.state), 1);
                check("restart_seq", 32'(bus.seq_err), 0);
            end
            if (t == 8) check("relocked", 32'(bus.valid), 1);
            if (t == 10) check("rev_after", 32'(bus.rev_count), 4);
        end

        tst = "skip";
        step(4'b0111, 1'b0);
        check("locked", 32'(bus.state), 2);
        step(4'b1111, 1'b0);
        check("pulse", 32'(bus.seq_err), 1);
        check("no_illegal", 32'(bus.illegal), 0);
        check("valid", 32'(bus.valid), 0);
        check("state", 32'(bus.state), 0);
        check("err", 32'(bus.err_count), 2);

        tst = "hold";
        for (int t = 0; t < 9; t++) begin
            step(T5[t], 1'b0);
            if (t == 4) begin
                check("lock_no_wrap", 32'(bus.wrap), 0);
                check("lock_state", 32'(bus.state), 2);
                check("lock_rev", 32'(bus.rev_count), 4);
            end
        end
        for (int k = 0; k < 5; k++) begin
            step(4'b1110, 1'b0);
            check("valid", 32'(bus.valid), 1);
            check("phase", 32'(bus.phase), 5);
            check("pulses", 32'({bus.illegal, bus.seq_err, bus.wrap}), 0);
            check("rev", 32'(bus.rev_count), 4);
        end

        tst = "midreset";
        step(4'b1100, 1'b1);

        tst = "sat";
        for (int k = 0; k < 300; k++) begin
            step(4'b1010, 1'b0);
        end
        check("err_sat", 32'(bus.err_count), 255);
        check("illegal", 32'(bus.illegal), 1);
        check("state", 32'(bus.state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/johnson_phase_monitor.md
# johnson_phase_monitor

Downstream consumer of the 4-bit Johnson counter's Q bus. Each cycle it registers the counter state and validates it against the 8-code Johnson set. It also checks that every transition is a legal successor or a hold. A lock state machine qualifies the decoded phase, and the block counts full revolutions and errors, so later stages can use a trusted phase index and one-hot strobe.

## Interface
- LOCK_STEPS, 4, consecutive good steps needed in TRACK to enter LOCKED; legal range 1..15.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high; takes effect at the rising edge of clk while high.
- q  input  4  Johnson counter state; bit 0 is the LSB.
- phase  output  3  index of the last legal code evaluated.
- phase_oh  output  8  one-hot of phase when valid=1; 8'h00 otherwise.
- valid  output  1  high while the state machine is in LOCKED.
- state  output  2  SEARCH=0, TRACK=1, LOCKED=2; 3 is unused.
- illegal  output  1  one-cycle pulse: the evaluated code is not a Johnson code.
- seq_err  output  1  one-cycle pulse: the code is legal but is neither a hold nor the successor.
- wrap  output  1  one-cycle pulse: phase 7 to phase 0 step taken while LOCKED.
- rev_count  output  8  count of wrap pulses, modulo 256.
- err_count  output  8  count of illegal plus seq_err pulses; saturates at 255.

## Operation
- Legal codes and phases, in order 0..7: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
- Successor of code c is {c[2:0], ~c[3]}.
- Pipeline:
  - q_r <= q on every edge.
  - cur = q_r; prev = the value of q_r from the previous cycle.
  - Each edge evaluates cur against prev and registers all outputs.
- Classification of each evaluation:
  - ILLEGAL: cur is not in the legal set.
  - SKIP: prev is legal, cur is legal, and cur is neither prev nor successor(prev).
  - HOLD: cur == prev and cur is legal.
  - GOOD: cur == successor(prev) and prev is legal.
  - A legal cur following an illegal prev counts as neither GOOD nor SKIP (a "restart").
- Pulse outputs:
  - illegal=1 on ILLEGAL; seq_err=1 on SKIP. They are mutually exclusive.
  - Either pulse increments err_count (saturating at 255).
- State machine (state registered; reset state SEARCH):
  - SEARCH: legal cur goes to TRACK with good_cnt=0; ILLEGAL stays in SEARCH.
  - TRACK:
    - GOOD increments good_cnt; when good_cnt reaches LOCK_STEPS, go to LOCKED.
    - HOLD leaves state and good_cnt unchanged.
    - ILLEGAL or SKIP goes to SEARCH.
  - LOCKED: GOOD or HOLD stays; ILLEGAL or SKIP goes to SEARCH.
  - valid falls on the same edge the error pulse rises.
- phase:
  - Updates to the index of cur whenever cur is legal.
  - Holds its previous value on ILLEGAL.
- wrap and rev_count:
  - wrap=1 and rev_count+1 only when the pre-edge state is LOCKED and the step is GOOD from 1000 to 0000.
  - Wraps seen in TRACK, including on the edge that enters LOCKED, are not counted.
- Reset values (any edge with reset=1):
  - q_r=0000, prev=0000, state=SEARCH, good_cnt=0.
  - phase=0, phase_oh=8'h00, valid=0, illegal=0, seq_err=0, wrap=0, rev_count=0, err_count=0.
- Reset asserted mid-operation clears all of the above on that edge, with no partial updates.

## Timing
- Latency:
  - q presented before edge n is captured into q_r at edge n.
  - Its classification and all outputs become visible after edge n+1, i.e. 2 edges from q to output.
- The first evaluation after reset release compares against prev=0000. A counter leaving reset from 0000 is therefore seen as HOLD, then GOOD.
- With LOCK_STEPS=4:
  - Earliest valid=1 is on the output cycle that evaluates the 4th GOOD step after entering TRACK.
  - A restart from SEARCH on the first legal code therefore gives valid=1 on the 5th evaluation at the earliest.
- All pulses are exactly one cycle wide. Back-to-back errors pulse on consecutive cycles.

## Test plan
1. Locking:
   - Stimulus: reset 2 cycles, release, drive q from 0000 and advance one code per clock.
   - Required: state goes 0 → 1 → 2; valid=1 after 4 GOOD steps; phase_oh=8'h01 at the first locked 0000; illegal, seq_err and err_count all stay 0.
2. Revolutions:
   - Stimulus: after lock, run 16 more steps.
   - Required: wrap pulses exactly twice, each on the 1000 → 0000 evaluation; rev_count=2.
3. Illegal code:
   - Stimulus: while LOCKED at phase 2 (0011), force q=1010 for one clock, then resume the legal sequence at 0011.
   - Required: illegal=1 for one cycle; valid=0; state=0; phase stays 2; err_count=1. The block then relocks after 4 GOOD steps with no seq_err.
4. Skip:
   - Stimulus: LOCKED, drive 0001 then 0111.
   - Required: seq_err=1 for one cycle; valid drops; err_count increments by 1.
5. Hold:
   - Stimulus: LOCKED, keep q=1110 for 5 clocks.
   - Required: valid stays 1; phase=5; no pulses; rev_count unchanged.
6. Reset and saturation:
   - Stimulus: assert reset mid-lock.
   - Required: every output takes its reset value after that edge.
   - Separately, inject 300 illegal codes; required: err_count=255.
